// File: rtl/branch_feedback_gen.sv
// branch_feedback_gen: tracks in-flight branch predictions, compares each with its
// resolved outcome and emits spaced PreRight/PreWrong report pulses.
//
// Ports:
//   clk, rst_n         clock; asynchronous active-low reset
//   stall              blocks prediction push, resolve and report issue
//   pred_valid, BrPre  a prediction (1 = taken) is issued this cycle
//   res_valid          the oldest in-flight branch resolves this cycle
//   res_taken          actual outcome of the resolving branch
//   PreRight/PreWrong  registered report pulses (one per outcome, IDLE/PULSE/GAP paced)
//   mispredict         pulse in the cycle after a wrong resolve
//   pred_full          prediction FIFO full
//   err                sticky: resolve on empty FIFO or report-queue overflow
module branch_feedback_gen #(
    parameter int PRED_DEPTH = 4,
    parameter int RPT_DEPTH  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    input  logic BrPre,
    input  logic pred_valid,
    input  logic res_valid,
    input  logic res_taken,
    output logic PreRight,
    output logic PreWrong,
    output logic mispredict,
    output logic pred_full,
    output logic err
);
    localparam int PW = $clog2(PRED_DEPTH);
    localparam int RW = $clog2(RPT_DEPTH);
    localparam logic [PW:0] PRED_FULL = (PW+1)'(PRED_DEPTH);
    localparam logic [RW:0] RPT_FULL  = (RW+1)'(RPT_DEPTH);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    state_t                state_q, state_d;
    logic [PRED_DEPTH-1:0] pred_mem_q, pred_mem_d;
    logic [PW-1:0]         pwr_q, pwr_d, prd_q, prd_d;
    logic [PW:0]           pcnt_q, pcnt_d;
    logic [RPT_DEPTH-1:0]  rpt_mem_q, rpt_mem_d;
    logic [RW-1:0]         rwr_q, rwr_d, rrd_q, rrd_d;
    logic [RW:0]           rcnt_q, rcnt_d;
    logic                  pre_right_q, pre_right_d, pre_wrong_q, pre_wrong_d;
    logic                  mispredict_q, mispredict_d, err_q, err_d;
    logic                  push, res, pop, wrong, rpt_pop, enq, issue;

    // Prediction FIFO: a wrong outcome flushes everything, including a same-cycle push.
    always_comb begin
        pred_full  = pcnt_q == PRED_FULL;
        push       = pred_valid && !stall && !pred_full;
        res        = res_valid && !stall;
        pop        = res && pcnt_q != '0;
        wrong      = pop && (pred_mem_q[prd_q] != res_taken);
        pred_mem_d = pred_mem_q;
        pwr_d      = pwr_q;
        prd_d      = prd_q;
        pcnt_d     = pcnt_q;
        if (wrong) begin
            prd_d  = pwr_q;
            pcnt_d = '0;
        end else begin
            if (push) begin
                pred_mem_d[pwr_q] = BrPre;
                pwr_d             = pwr_q + 1'b1;
            end
            if (pop) prd_d = prd_q + 1'b1;
            pcnt_d = pcnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    // Report queue: stores 1 for WRONG; a full queue still accepts when the head leaves this cycle.
    always_comb begin
        rpt_pop   = state_q == PULSE && !stall;
        enq       = pop && (rcnt_q != RPT_FULL || rpt_pop);
        rpt_mem_d = rpt_mem_q;
        rwr_d     = rwr_q;
        if (enq) begin
            rpt_mem_d[rwr_q] = wrong;
            rwr_d            = rwr_q + 1'b1;
        end
        rrd_d        = rpt_pop ? rrd_q + 1'b1 : rrd_q;
        rcnt_d       = rcnt_q + {{RW{1'b0}}, enq} - {{RW{1'b0}}, rpt_pop};
        mispredict_d = wrong;
        err_d        = err_q || (res && pcnt_q == '0) || (pop && !enq);
    end

    // Emitter FSM; the pulse flops are loaded on entry to PULSE so outputs come straight from flops.
    always_comb begin
        issue       = state_q == IDLE && rcnt_q != '0 && !stall;
        state_d     = state_q == IDLE ? (issue ? PULSE : IDLE) : state_q == PULSE ? GAP : IDLE;
        pre_right_d = issue && !rpt_mem_q[rrd_q];
        pre_wrong_d = issue && rpt_mem_q[rrd_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pred_mem_q   <= '0;
            pwr_q        <= '0;
            prd_q        <= '0;
            pcnt_q       <= '0;
            rpt_mem_q    <= '0;
            rwr_q        <= '0;
            rrd_q        <= '0;
            rcnt_q       <= '0;
            pre_right_q  <= 1'b0;
            pre_wrong_q  <= 1'b0;
            mispredict_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pred_mem_q   <= pred_mem_d;
            pwr_q        <= pwr_d;
            prd_q        <= prd_d;
            pcnt_q       <= pcnt_d;
            rpt_mem_q    <= rpt_mem_d;
            rwr_q        <= rwr_d;
            rrd_q        <= rrd_d;
            rcnt_q       <= rcnt_d;
            pre_right_q  <= pre_right_d;
            pre_wrong_q  <= pre_wrong_d;
            mispredict_q <= mispredict_d;
            err_q        <= err_d;
        end
    end

    assign PreRight   = pre_right_q;
    assign PreWrong   = pre_wrong_q;
    assign mispredict = mispredict_q;
    assign err        = err_q;
endmodule

// File: tb/tb_branch_feedback_gen.sv
// tb_branch_feedback_gen: scoreboard bench for branch_feedback_gen; stimulus queues
// expected reports/mispredicts, a negedge monitor pops and compares them.
module tb_branch_feedback_gen;
    logic clk = 0, rst_n = 1, stall = 0, BrPre = 0, pred_valid = 0, res_valid = 0, res_taken = 0;
    logic PreRight, PreWrong, mispredict, pred_full, err;
    int   checks = 0, errors = 0, cyc = 0, last_pulse = -100;
    bit   exp_rpt[$];
    int   exp_mis[$];
    int   pulse_log[$];

    branch_feedback_gen #(.PRED_DEPTH(4), .RPT_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .BrPre(BrPre), .pred_valid(pred_valid),
        .res_valid(res_valid), .res_taken(res_taken), .PreRight(PreRight), .PreWrong(PreWrong),
        .mispredict(mispredict), .pred_full(pred_full), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a pulse while stall is high is withheld and must be reissued, so it is not popped.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_rpt.delete();
            exp_mis.delete();
            last_pulse = -100;
        end else begin
            if (PreRight || PreWrong) begin
                chk("pulse_spacing", 32'(cyc - last_pulse >= 3), 1);
                last_pulse = cyc;
                pulse_log.push_back(cyc);
                if (exp_rpt.size() == 0) chk("unexpected_pulse", {PreRight, PreWrong}, 2'b00);
                else begin
                    chk("pulse_kind", {PreRight, PreWrong}, exp_rpt[0] ? 2'b01 : 2'b10);
                    if (!stall) void'(exp_rpt.pop_front());
                end
            end
            if (mispredict) begin
                if (exp_mis.size() == 0) chk("unexpected_mispredict", mispredict, 0);
                else chk("mispredict_cycle", cyc, exp_mis.pop_front());
            end
        end
    end

    task automatic drive(input logic pv, input logic bp, input logic rv, input logic rt, input logic st);
        pred_valid = pv; BrPre = bp; res_valid = rv; res_taken = rt; stall = st;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; pred_valid = 0; BrPre = 0; res_valid = 0; res_taken = 0; stall = 0;
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && (exp_rpt.size() != 0 || exp_mis.size() != 0); i++) drive(0, 0, 0, 0, 0);
        repeat (6) drive(0, 0, 0, 0, 0);
        chk({name, "_drained"}, exp_rpt.size() + exp_mis.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        #1 rst_n = 0;
        #1 chk("reset_outputs", {PreRight, PreWrong, mispredict, err, pred_full}, 0);
        @(posedge clk);
        #1 rst_n = 1;

        // single right prediction
        drive(1, 1, 0, 0, 0);
        exp_rpt.push_back(0);
        drive(0, 0, 1, 1, 0);
        drain("t030");
        chk("t030_err", err, 0);

        // wrong resolve flushes the FIFO (and the same-cycle push); next resolve hits empty
        do_reset();
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        exp_rpt.push_back(1);
        exp_mis.push_back(cyc + 1);
        drive(1, 1, 1, 0, 0);
        chk("t031_err_before", err, 0);
        drive(0, 0, 1, 0, 0);
        chk("t031_err_after_empty_resolve", err, 1);
        drain("t031");

        // four back-to-back right resolves: pulses every third cycle
        do_reset();
        repeat (4) drive(1, 1, 0, 0, 0);
        base = pulse_log.size();
        repeat (4) begin
            exp_rpt.push_back(0);
            drive(0, 0, 1, 1, 0);
        end
        drain("t032");
        chk("t032_pulse_count", pulse_log.size() - base, 4);
        if (pulse_log.size() >= base + 4)
            for (int k = 1; k < 4; k++) chk("t032_pulse_period", pulse_log[base+k] - pulse_log[base+k-1], 3);
        chk("t032_err", err, 0);

        // stall raised during PULSE: pulse withheld, same outcome reissued
        do_reset();
        drive(1, 1, 0, 0, 0);
        exp_rpt.push_back(0);
        drive(0, 0, 1, 1, 0);
        for (int i = 0; i < 10 && !PreRight; i++) drive(0, 0, 0, 0, 0);
        chk("t033_pulse_seen", PreRight, 1);
        drive(0, 0, 0, 0, 1);
        chk("t033_pulse_ends", PreRight, 0);
        drain("t033");

        // prediction FIFO full drop, then report-queue overflow on the 7th resolve
        do_reset();
        repeat (4) drive(1, 1, 0, 0, 0);
        chk("t034_pred_full", pred_full, 1);
        drive(1, 0, 0, 0, 0);
        chk("t034_full_after_drop", pred_full, 1);
        chk("t034_no_err_on_full_push", err, 0);
        repeat (6) exp_rpt.push_back(0);
        drive(0, 0, 1, 1, 0);
        repeat (5) drive(1, 1, 1, 1, 0);
        chk("t034_err_before_overflow", err, 0);
        drive(1, 1, 1, 1, 0);
        chk("t034_err_overflow", err, 1);
        drain("t034");

        // reset mid-operation: 2 predictions and 2 reports pending, a pulse on the wire
        do_reset();
        repeat (4) drive(1, 1, 0, 0, 0);
        drive(0, 0, 1, 1, 0);
        drive(0, 0, 1, 1, 0);
        chk("t035_pulse_before_reset", PreRight, 1);
        rst_n = 0;
        #1 chk("t035_async_clear", {PreRight, PreWrong, mispredict, err, pred_full}, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1;
        repeat (10) drive(0, 0, 0, 0, 0);
        chk("t035_err_after_reset", err, 0);
        drive(1, 0, 0, 0, 0);
        exp_rpt.push_back(0);
        drive(0, 0, 1, 0, 0);
        drain("t035");
        chk("t035_err_final", err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
